// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath and its memory, plus the preload port.
// Latency: none, wires only.
// Backpressure: requests are level strobes held until Done is seen.
interface mem_responder_if #(
  parameter int BITS      = 32,
  parameter int ADDR_BITS = 9
);
  logic                 Read;
  logic                 Write;
  logic [ADDR_BITS-1:0] MARaddr;
  logic [BITS-1:0]      MDRdata;
  logic [BITS-1:0]      Mdatain;
  logic                 Done;
  logic                 Busy;
  logic                 ProgWe;
  logic [ADDR_BITS-1:0] ProgAddr;
  logic [BITS-1:0]      ProgData;

  // Datapath / bench side
  modport master (
    output Read, Write, MARaddr, MDRdata, ProgWe, ProgAddr, ProgData,
    input  Mdatain, Done, Busy
  );

  // Memory side
  modport slave (
    input  Read, Write, MARaddr, MDRdata, ProgWe, ProgAddr, ProgData,
    output Mdatain, Done, Busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM answering datapath Read/Write strobes with a one-cycle Done pulse.
// Latency: Done high in the cycle after edge k+WAIT_STATES+1 when the request is captured at edge k.
// Backpressure: four-phase; HOLD waits for both strobes low, preload is honoured only when idle.
module mem_responder #(
  parameter int BITS        = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic            Clock,
  input  logic            Resetn,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]      data_q, data_d;
  logic [BITS-1:0]      mdat_q, mdat_d;
  logic                 done_q, done_d;

  logic [BITS-1:0]      mem [DEPTH];

  // State and captured-request registers; the array itself is not reset
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mdat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mdat_q  <= mdat_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture in IDLE, count in WAIT, access in RESP, wait for strobes low in HOLD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mdat_d  = mdat_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Read || bus.Write) begin
          // Both strobes together resolve to a read; the write is dropped
          op_wr_d = bus.Write && !bus.Read;
          addr_d  = bus.MARaddr;
          data_d  = bus.MDRdata;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d = 1'b1;
        if (!op_wr_q) begin
          mdat_d = mem[addr_q];
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.Read && !bus.Write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array writes: preload only while idle, datapath write in RESP; nothing lands while reset is held
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      if (state_q == S_IDLE && bus.ProgWe) begin
        mem[bus.ProgAddr] <= bus.ProgData;
      end else if (state_q == S_RESP && op_wr_q) begin
        mem[addr_q] <= data_q;
      end
    end
  end

  assign bus.Mdatain = mdat_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Three responders (0, 1 and 3 wait states) driven in lockstep from one stimulus stream.
// Latency: each instance is checked against its own WAIT_STATES+1.
// Backpressure: strobes are held until every instance has pulsed Done, then dropped.
module tb_mem_responder;

  localparam int BITS = 32;
  localparam int AB   = 9;
  localparam int WS0  = 0;
  localparam int WS1  = 1;
  localparam int WS3  = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            rd, wr, pwe;
  logic [AB-1:0]   addr, paddr;
  logic [BITS-1:0] wdat, pdat;

  always #5 clk = ~clk;

  mem_responder_if #(.BITS(BITS), .ADDR_BITS(AB)) b0 ();
  mem_responder_if #(.BITS(BITS), .ADDR_BITS(AB)) b1 ();
  mem_responder_if #(.BITS(BITS), .ADDR_BITS(AB)) b2 ();

  assign b0.Read = rd;   assign b1.Read = rd;   assign b2.Read = rd;
  assign b0.Write = wr;  assign b1.Write = wr;  assign b2.Write = wr;
  assign b0.MARaddr = addr;  assign b1.MARaddr = addr;  assign b2.MARaddr = addr;
  assign b0.MDRdata = wdat;  assign b1.MDRdata = wdat;  assign b2.MDRdata = wdat;
  assign b0.ProgWe = pwe;    assign b1.ProgWe = pwe;    assign b2.ProgWe = pwe;
  assign b0.ProgAddr = paddr; assign b1.ProgAddr = paddr; assign b2.ProgAddr = paddr;
  assign b0.ProgData = pdat;  assign b1.ProgData = pdat;  assign b2.ProgData = pdat;

  mem_responder #(.BITS(BITS), .ADDR_BITS(AB), .WAIT_STATES(WS0)) dut0 (
    .Clock(clk), .Resetn(rstn), .bus(b0));
  mem_responder #(.BITS(BITS), .ADDR_BITS(AB), .WAIT_STATES(WS1)) dut1 (
    .Clock(clk), .Resetn(rstn), .bus(b1));
  mem_responder #(.BITS(BITS), .ADDR_BITS(AB), .WAIT_STATES(WS3)) dut3 (
    .Clock(clk), .Resetn(rstn), .bus(b2));

  logic [2:0]      done_a, busy_a;
  logic [BITS-1:0] mdat_a [3];

  assign done_a = {b2.Done, b1.Done, b0.Done};
  assign busy_a = {b2.Busy, b1.Busy, b0.Busy};
  assign mdat_a[0] = b0.Mdatain;
  assign mdat_a[1] = b1.Mdatain;
  assign mdat_a[2] = b2.Mdatain;

  int checks = 0;
  int errors = 0;

  logic [BITS-1:0] sb_q [$];

  typedef struct {
    logic            rd;
    logic            wr;
    logic [AB-1:0]   addr;
    logic [BITS-1:0] wdata;
    logic [BITS-1:0] exp;
  } vec_t;

  vec_t vec [8];

  function automatic int exp_lat(input int d);
    case (d)
      0:       return WS0 + 1;
      1:       return WS1 + 1;
      default: return WS3 + 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic prog(input logic [AB-1:0] a, input logic [BITS-1:0] d);
    pwe = 1'b1; paddr = a; pdat = d;
    @(posedge clk); #1;
    pwe = 1'b0;
  endtask

  // mode 0: plain, 1: change inputs after capture, 2: ProgWe while busy,
  // 3: preload on the capture edge, 4: drop strobes right after capture
  task automatic txn(input logic r, input logic w, input logic [AB-1:0] a,
                     input logic [BITS-1:0] d, input logic [BITS-1:0] exp,
                     input int mode, input string nm);
    logic [2:0]      seen;
    int              lat [3];
    logic [BITS-1:0] got [3];
    logic [BITS-1:0] exp_v;
    int              n;
    rd = r; wr = w; addr = a; wdat = d;
    if (mode == 3) begin
      pwe = 1'b1; paddr = a; pdat = d;
    end
    sb_q.push_back(exp);
    @(posedge clk); #1;
    pwe = 1'b0;
    chk($sformatf("%s busy_after_capture", nm), 32'(busy_a), 32'h7);
    case (mode)
      1: begin addr = 9'h100; wdat = ~d; end
      2: begin pwe = 1'b1; paddr = 9'h060; pdat = 32'h77777777; end
      4: begin rd = 1'b0; wr = 1'b0; end
      default: ;
    endcase
    seen = '0;
    n = 0;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; got[i] = '0; end
    while (n < 16 && !(seen == 3'b111 && n >= exp_lat(2) + 1)) begin
      @(posedge clk); #1;
      n++;
      pwe = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] && n == lat[i] + 1) begin
          chk($sformatf("%s done_width d%0d", nm, i), 32'(done_a[i]), 32'h0);
          chk($sformatf("%s busy_after_done d%0d", nm, i), 32'(busy_a[i]),
              (mode == 4) ? 32'h0 : 32'h1);
        end else if (done_a[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = n;
          got[i]  = mdat_a[i];
        end
      end
    end
    checks++;
    if (seen != 3'b111) begin
      errors++;
      $display("FAIL %s done_timeout actual=%b required=111", nm, seen);
    end
    exp_v = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s latency d%0d", nm, i), 32'(lat[i]), 32'(exp_lat(i)));
      chk($sformatf("%s mdatain d%0d", nm, i), got[i], exp_v);
    end
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s idle_after_release", nm), 32'(busy_a), 32'h0);
  endtask

  initial begin
    vec[0] = '{1'b1, 1'b0, 9'h000, 32'h00000000, 32'h4A920000};
    vec[1] = '{1'b0, 1'b1, 9'h022, 32'h00000026, 32'h4A920000};
    vec[2] = '{1'b1, 1'b0, 9'h022, 32'h00000000, 32'h00000026};
    vec[3] = '{1'b1, 1'b1, 9'h022, 32'hFFFFFFFF, 32'h00000026};
    vec[4] = '{1'b1, 1'b0, 9'h022, 32'h00000000, 32'h00000026};
    vec[5] = '{1'b0, 1'b1, 9'h1FF, 32'hA5A50001, 32'h00000026};
    vec[6] = '{1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'hA5A50001};
    vec[7] = '{1'b1, 1'b0, 9'h050, 32'h00000000, 32'h12345678};

    rstn = 1'b0; rd = 1'b0; wr = 1'b0; pwe = 1'b0;
    addr = '0; paddr = '0; wdat = '0; pdat = '0;
    #1;
    chk("reset busy", 32'(busy_a), 32'h0);
    chk("reset done", 32'(done_a), 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset mdatain d%0d", i), mdat_a[i], 32'h0);
    #20;
    rstn = 1'b1;
    @(posedge clk); #1;

    prog(9'h000, 32'h4A920000);
    prog(9'h050, 32'h12345678);
    prog(9'h100, 32'h0BAD0100);
    prog(9'h060, 32'h11111111);

    for (int i = 0; i < 8; i++) begin
      txn(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].exp, 0,
          $sformatf("vec%0d", i));
    end

    txn(1'b1, 1'b0, 9'h000, 32'h0, 32'h4A920000, 1, "input_change");
    txn(1'b1, 1'b0, 9'h060, 32'h0, 32'h11111111, 2, "progwe_busy");
    txn(1'b1, 1'b0, 9'h070, 32'hCAFE0070, 32'hCAFE0070, 3, "prog_same_edge");
    txn(1'b1, 1'b0, 9'h022, 32'h0, 32'h00000026, 4, "early_drop");

    // Reset lands while the write is still in flight in every instance
    rd = 1'b0; wr = 1'b1; addr = 9'h050; wdat = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("midwrite busy_before_reset", 32'(busy_a), 32'h7);
    rstn = 1'b0;
    #1;
    chk("midwrite busy", 32'(busy_a), 32'h0);
    chk("midwrite done", 32'(done_a), 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("midwrite mdatain d%0d", i), mdat_a[i], 32'h0);
    wr = 1'b0;
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 9'h050, 32'h0, 32'h12345678, 0, "after_reset_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed synchronous RAM that answers the datapath's memory requests (MAR address, Read/Write strobes, MDR write data) and returns read data on Mdatain with a completion pulse.
- Replaces the testbench-driven Mdatain stimulus, so the datapath can fetch instructions and operands from a real memory.
- Uses a four-phase request/Done handshake with a configurable access latency.
- Provides a side programming port so benches can preload code and data.

Parameters:
- BITS, 32, data word width
- ADDR_BITS, 9, address width; depth = 2**ADDR_BITS words
- WAIT_STATES, 1, extra cycles between request capture and completion (0..15)

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous active-low reset
- Read  in  1  read request, level, held until Done seen
- Write  in  1  write request, level, held until Done seen
- MARaddr  in  ADDR_BITS  request address, from MAR
- MDRdata  in  BITS  write data, from MDR
- Mdatain  out  BITS  read data to MDR input mux
- Done  out  1  one-cycle completion pulse
- Busy  out  1  high whenever state is not IDLE
- ProgWe  in  1  preload write enable, honoured only in IDLE
- ProgAddr  in  ADDR_BITS  preload address
- ProgData  in  BITS  preload data

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=IDLE, Mdatain=0, Done=0, Busy=0, wait counter=0.
  - Memory array contents are NOT cleared.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE, on each rising edge:
  - If Read|Write: capture op, MARaddr and MDRdata into internal registers.
  - Read=Write=1: treated as a read; the write is discarded.
  - Next state: WAIT with counter=WAIT_STATES, or RESP directly if WAIT_STATES=0.
- WAIT: decrement the counter each edge; when it reaches 1, go to RESP.
- RESP, one cycle:
  - Read: Mdatain <= mem[captured addr].
  - Write: mem[captured addr] <= captured data; Mdatain unchanged.
  - Done <= 1 for exactly one cycle; next state HOLD.
- HOLD: stay until Read=0 and Write=0 are sampled, then IDLE. This prevents a held strobe from retriggering.
- Latency: request sampled at edge k; Done is high in the cycle after edge k+WAIT_STATES+1. For reads, Mdatain is valid in the same cycle as Done.
- Mdatain holds the last read value until the next read completes. Writes never alter Mdatain.
- Changes on Read, Write, MARaddr or MDRdata after capture have no effect on the transaction in flight.
- Dropping the strobe early, in WAIT, does not cancel the access: Done still pulses, and HOLD exits immediately afterwards.
- ProgWe:
  - In IDLE: mem[ProgAddr] <= ProgData.
  - Ignored in every other state.
- ProgWe together with a request in IDLE: the preload lands first. A read to the same address returns ProgData, because the array read occurs later in RESP.
- Address range: fully decoded, no out-of-range case. Addresses wrap naturally at 2**ADDR_BITS.
- Reset mid-operation: the transaction is abandoned; a pending write is not performed; Done never pulses.
- Busy = (state != IDLE). It is registered from state, not combinational on the request inputs.

Test Plan:
- Preload and read: with WAIT_STATES=1, preload mem[0x000]=0x4A920000, then Read=1 at MARaddr=0x000.
  - Done pulses exactly 2 cycles after capture, with Mdatain=0x4A920000.
  - HOLD is held while Read stays 1; IDLE follows one edge after Read drops.
- Write then read back: Write=1 with MARaddr=0x022 and MDRdata=0x00000026.
  - Done pulses and Mdatain is unchanged (still 0x4A920000).
  - A subsequent Read of 0x022 returns 0x00000026.
- Simultaneous strobes: Read=Write=1 at 0x022 with MDRdata=0xFFFFFFFF returns 0x00000026. A later read confirms memory is unchanged.
- Input change after capture: change MARaddr to 0x100 one cycle after a read of 0x000 is captured. Mdatain still returns 0x4A920000.
- Reset mid-write: pulse Resetn=0 during WAIT of a write of 0xDEADBEEF to 0x050 (preloaded 0x12345678).
  - Immediately after reset: Busy=0, Done=0, Mdatain=0.
  - A read of 0x050 returns 0x12345678.
- Latency sweep and ProgWe gating: run with WAIT_STATES=0 and WAIT_STATES=3.
  - Done appears 1 and 4 cycles after capture respectively.
  - ProgWe asserted while Busy=1 leaves the target word unchanged.
